chorus_sample_scheduler: RTL
============================

# chorus_sample_scheduler

- Sequences the chorus filter datapath once per audio sample.
- Accepts a 16-bit sample strobe from the codec input side, holds the sample stable for the filter, issues exactly one filter `enable` pulse, and waits the filter's fixed read latency.
- Captures the filter output and presents it to the codec output side with a valid/ready handshake.
- Sits between the audio codec interface and the chorus filter. It is the sole driver of the filter's `enable` and `dataIn`.

## Interface
Parameters:
- `DATA_W`, 16, sample width.
- `LAT`, 2, cycles from the filter `enable` cycle to valid `dataOut`. Legal range 1..15.
- `DROP_W`, 8, width of the saturating dropped-sample counter.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  single-cycle sample strobe from the codec. No backpressure at the source.
- `in_data`  in  DATA_W  input sample, valid with `in_valid`.
- `in_ready`  out  1  high when a strobe this cycle will be accepted.
- `filt_enable`  out  1  to the filter `enable`. One-cycle pulse per accepted sample.
- `filt_data_in`  out  DATA_W  to the filter `dataIn`. Holds the accepted sample.
- `filt_data_out`  in  DATA_W  from the filter `dataOut`.
- `out_valid`  out  1  processed sample available.
- `out_data`  out  DATA_W  processed sample. Stable while `out_valid` is high.
- `out_ready`  in  1  codec output side accepts.
- `busy`  out  1  state is not IDLE.
- `drop_count`  out  DROP_W  saturating count of rejected strobes.

## Operation
- Reset state is IDLE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`: register `in_data` into `filt_data_in`, go to STROBE.
- STROBE
  - One cycle with `filt_enable`=1, then go to WAIT with the wait counter cleared.
- WAIT
  - Lasts `LAT` cycles.
  - On the last WAIT cycle, register `filt_data_out` into `out_data`, set `out_valid`, go to HOLD.
- HOLD
  - `out_valid`=1 until `out_ready`=1.
  - `in_ready` = `out_ready`.
  - `out_ready` && `in_valid` in the same cycle: complete the output, accept the new sample, go directly to STROBE. No bubble.
  - `out_ready` only: go to IDLE.
- Drops
  - `in_valid` while `in_ready`=0 discards the sample and increments `drop_count`.
  - `drop_count` saturates at all-ones and clears only on reset.
- `filt_data_in` changes only on an accepted sample. It is stable from STROBE through the end of WAIT.
- `filt_enable` is never high outside STROBE. Exactly one pulse per accepted sample.
- Samples are passed through untouched. No arithmetic or width conversion.

## Timing
- Reset values while `reset` is high and in the first cycle after:
  - `filt_enable`=0, `filt_data_in`=0, `out_valid`=0, `out_data`=0, `busy`=0, `drop_count`=0.
  - `in_ready`=1 after reset releases.
  - `in_valid` during reset is ignored and not counted.
- Latency: `in_valid` accepted at cycle 0; `filt_enable` high in cycle 1; WAIT in cycles 2..1+LAT; `out_valid` rises in cycle 2+LAT. Default LAT=2 gives cycle 4.
- Minimum sample period with `out_ready` held high: 2+LAT cycles.
- Reset mid-operation: abort immediately, return to IDLE. An in-flight sample is lost and not counted as a drop.
- All outputs are registered except `in_ready` and `busy`, which decode from state.

## Configuration
- Macro: `CHORUS_SCHED_BYPASS_EN`.
- Defined:
  - Adds input port `bypass` (1 bit).
  - When `bypass`=1 on the last WAIT cycle, `out_data` captures `filt_data_in` instead of `filt_data_out`.
  - The filter is still strobed, so the LFO phase and buffer contents keep advancing and toggling bypass causes no discontinuity.
- Undefined: no `bypass` port; `out_data` always comes from `filt_data_out`.

## Structure
- Shared package `chorus_pkg`:
  - `DATA_W` default constant.
  - State enum `sched_state_t` {IDLE, STROBE, WAIT, HOLD}.
  - `LAT` default constant, shared with the filter so latency stays consistent.
- No sub-module. The wait counter and saturating drop counter are inline.

## Test plan
- Single sample, LAT=2, `out_ready`=1, filter model returns input+1: `in_data`=16'h1234 at cycle 0 -> `filt_enable` pulse in cycle 1 only, `out_valid` at cycle 4, `out_data`=16'h1235.
- Backpressure: `out_ready`=0 for 10 cycles, then a second `in_valid` in HOLD -> `drop_count`=1, `out_data` unchanged. Raising `out_ready` completes the transfer.
- Back-to-back: `out_ready`=1, strobes every 4 cycles for 8 samples -> 8 `filt_enable` pulses, 8 outputs in order, `drop_count`=0.
- Saturation: 300 strobes while stalled in HOLD -> `drop_count`=8'hFF.
- Reset in WAIT -> next cycle IDLE, `out_valid`=0, `filt_enable`=0. A following sample processes normally.
- With `CHORUS_SCHED_BYPASS_EN` and `bypass`=1, `in_data`=16'hABCD -> `out_data`=16'hABCD and `filt_enable` still pulses once.

Source files
------------

// File: rtl/chorus_pkg.sv
// Shared constants and scheduler state encoding for the chorus datapath.
package chorus_pkg;

  localparam int CHORUS_DATA_W = 16;
  // Filter read latency; the filter uses this same constant.
  localparam int CHORUS_LAT    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/chorus_sample_scheduler.sv
// Per-sample sequencer: latch codec sample, pulse filter enable, wait LAT, present result.
// Optional CHORUS_SCHED_BYPASS_EN adds a bypass port routing the held input to out_data.
module chorus_sample_scheduler
  import chorus_pkg::*;
#(
  parameter int DATA_W = CHORUS_DATA_W,
  parameter int LAT    = CHORUS_LAT,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
`ifdef CHORUS_SCHED_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              filt_enable,
  output logic [DATA_W-1:0] filt_data_in,
  input  logic [DATA_W-1:0] filt_data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [3:0] WAIT_LAST = 4'(LAT - 1);

  sched_state_t      state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] fdin_q, fdin_d;
  logic              fen_q, fen_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DATA_W-1:0] capture_src;

  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign busy     = (state_q != IDLE);

`ifdef CHORUS_SCHED_BYPASS_EN
  // Filter is still strobed in bypass so its internal state keeps advancing.
  assign capture_src = bypass ? fdin_q : filt_data_out;
`else
  assign capture_src = filt_data_out;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fdin_d  = fdin_q;
    fen_d   = 1'b0;
    ov_d    = ov_q;
    od_d    = od_q;
    drop_d  = drop_q;

    if (in_valid && !in_ready && (drop_q != '1))
      drop_d = drop_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fdin_d  = in_data;
          fen_d   = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        wcnt_d  = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          od_d    = capture_src;
          ov_d    = 1'b1;
          state_d = HOLD;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_d = 1'b0;
          // Completing the output and accepting the next sample share a cycle.
          if (in_valid) begin
            fdin_d  = in_data;
            fen_d   = 1'b1;
            state_d = STROBE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      fdin_q  <= '0;
      fen_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fdin_q  <= fdin_d;
      fen_q   <= fen_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      drop_q  <= drop_d;
    end
  end

  assign filt_enable  = fen_q;
  assign filt_data_in = fdin_q;
  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign drop_count   = drop_q;

endmodule
